// File: rtl/pc_stack_unit.sv
// Program counter with a LIFO return-address stack.
// Level requests act once, on their rising edge, in ret > call > jmp > br > inc order.
module pc_stack_unit #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4,
   parameter int INC    = 1,
   parameter int SP_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_req,
   input  logic              jmp_req,
   input  logic              br_req,
   input  logic              br_cond,
   input  logic              call_req,
   input  logic              ret_req,
   input  logic [ADDR_W-1:0] target,
   input  logic              err_clr,
   output logic [ADDR_W-1:0] pc,
   output logic [SP_W-1:0]   sp,
   output logic              stk_full,
   output logic              stk_empty,
   output logic              stk_err,
   output logic              pc_upd
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);
   localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);
   localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

   logic inc_d, jmp_d, br_d, call_d, ret_d;
   logic inc_e, jmp_e, br_e, call_e, ret_e;
   logic win_inc, win_jmp, win_br, win_call, win_ret;
   logic push;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic [ADDR_W-1:0] pc_seq;
   logic [ADDR_W-1:0] stack [DEPTH];

   assign stk_full  = (sp == SP_MAX);
   assign stk_empty = (sp == '0);
   assign pc_seq    = pc + STEP;
   assign wr_idx    = IDX_W'(sp);
   assign rd_idx    = IDX_W'(sp - SP_ONE);

   assign inc_e  = inc_req  & ~inc_d;
   assign jmp_e  = jmp_req  & ~jmp_d;
   assign br_e   = br_req   & ~br_d;
   assign call_e = call_req & ~call_d;
   assign ret_e  = ret_req  & ~ret_d;

   // One-hot winner; losing edges are simply dropped.
   always_comb begin
      win_ret  = ret_e;
      win_call = call_e & ~ret_e;
      win_jmp  = jmp_e & ~ret_e & ~call_e;
      win_br   = br_e & ~ret_e & ~call_e & ~jmp_e;
      win_inc  = inc_e & ~ret_e & ~call_e & ~jmp_e & ~br_e;
   end

   assign push = win_call & ~stk_full;

   always_ff @(posedge clk) begin
      if (push)
         stack[wr_idx] <= pc_seq;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= '0;
         sp      <= '0;
         stk_err <= 1'b0;
         pc_upd  <= 1'b0;
         inc_d   <= 1'b0;
         jmp_d   <= 1'b0;
         br_d    <= 1'b0;
         call_d  <= 1'b0;
         ret_d   <= 1'b0;
      end else begin
         inc_d  <= inc_req;
         jmp_d  <= jmp_req;
         br_d   <= br_req;
         call_d <= call_req;
         ret_d  <= ret_req;
         pc_upd <= 1'b0;
         if (err_clr)
            stk_err <= 1'b0;
         // A new error below overrides the clear.
         unique case (1'b1)
            win_ret: begin
               if (stk_empty) begin
                  stk_err <= 1'b1;
               end else begin
                  pc     <= stack[rd_idx];
                  sp     <= sp - SP_ONE;
                  pc_upd <= 1'b1;
               end
            end
            win_call: begin
               if (stk_full) begin
                  stk_err <= 1'b1;
               end else begin
                  pc     <= target;
                  sp     <= sp + SP_ONE;
                  pc_upd <= 1'b1;
               end
            end
            win_jmp: begin
               pc     <= target;
               pc_upd <= 1'b1;
            end
            win_br: begin
               if (br_cond) begin
                  pc     <= target;
                  pc_upd <= 1'b1;
               end
            end
            win_inc: begin
               pc     <= pc_seq;
               pc_upd <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: stimulus queues expected state,
// a monitor compares it one edge later.
module tb_pc_stack_unit;

   localparam logic [6:0] N   = 7'h00;
   localparam logic [6:0] I   = 7'h01;
   localparam logic [6:0] J   = 7'h02;
   localparam logic [6:0] B   = 7'h04;
   localparam logic [6:0] C   = 7'h08;
   localparam logic [6:0] R   = 7'h10;
   localparam logic [6:0] BC  = 7'h20;
   localparam logic [6:0] CLR = 7'h40;

   logic       clk;
   logic       rst_n;
   logic       inc_req, jmp_req, br_req, br_cond;
   logic       call_req, ret_req, err_clr;
   logic [7:0] target;
   logic [7:0] pc;
   logic [2:0] sp;
   logic       stk_full, stk_empty, stk_err, pc_upd;

   typedef struct {
      string      nm;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       err;
      logic       upd;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int vectors = 0;
   int miscompares = 0;

   pc_stack_unit dut (
      .clk(clk), .rst_n(rst_n),
      .inc_req(inc_req), .jmp_req(jmp_req),
      .br_req(br_req), .br_cond(br_cond),
      .call_req(call_req), .ret_req(ret_req),
      .target(target), .err_clr(err_clr),
      .pc(pc), .sp(sp),
      .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_err(stk_err), .pc_upd(pc_upd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compare(input exp_t x);
      logic ef, ee;
      ef = (x.sp == 3'd4);
      ee = (x.sp == 3'd0);
      vectors++;
      if (pc !== x.pc || sp !== x.sp || stk_err !== x.err ||
          pc_upd !== x.upd || stk_full !== ef || stk_empty !== ee) begin
         miscompares++;
         $display("FAIL %s: got pc=%h sp=%0d err=%b upd=%b full=%b empty=%b; want pc=%h sp=%0d err=%b upd=%b full=%b empty=%b",
                  x.nm, pc, sp, stk_err, pc_upd, stk_full, stk_empty,
                  x.pc, x.sp, x.err, x.upd, ef, ee);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         compare(e);
      end
   end

   task automatic step(input string nm, input logic [6:0] cmd,
                       input logic [7:0] t, input logic [7:0] epc,
                       input logic [2:0] esp, input logic eerr,
                       input logic eupd);
      @(negedge clk);
      inc_req  = cmd[0];
      jmp_req  = cmd[1];
      br_req   = cmd[2];
      call_req = cmd[3];
      ret_req  = cmd[4];
      br_cond  = cmd[5];
      err_clr  = cmd[6];
      target   = t;
      q.push_back('{nm, epc, esp, eerr, eupd});
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() > 0; k++)
         @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      inc_req = 0; jmp_req = 0; br_req = 0; br_cond = 0;
      call_req = 0; ret_req = 0; err_clr = 0; target = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      step("reset",   N, 8'h00, 8'h00, 3'd0, 0, 0);
      step("inc1",    I, 8'h00, 8'h01, 3'd0, 0, 1);
      step("inc1_h",  I, 8'h00, 8'h01, 3'd0, 0, 0);
      step("inc1_l",  N, 8'h00, 8'h01, 3'd0, 0, 0);
      step("inc2",    I, 8'h00, 8'h02, 3'd0, 0, 1);
      step("inc2_h",  I, 8'h00, 8'h02, 3'd0, 0, 0);
      step("inc2_l",  N, 8'h00, 8'h02, 3'd0, 0, 0);

      step("jmp_ff",  J, 8'hFF, 8'hFF, 3'd0, 0, 1);
      step("jmp_l",   N, 8'h00, 8'hFF, 3'd0, 0, 0);
      step("wrap",    I, 8'h00, 8'h00, 3'd0, 0, 1);
      step("wrap_l",  N, 8'h00, 8'h00, 3'd0, 0, 0);

      step("jmp_10",  J, 8'h10, 8'h10, 3'd0, 0, 1);
      step("idle",    N, 8'h00, 8'h10, 3'd0, 0, 0);
      step("call_20", C, 8'h20, 8'h20, 3'd1, 0, 1);
      step("idle",    N, 8'h00, 8'h20, 3'd1, 0, 0);
      step("call_30", C, 8'h30, 8'h30, 3'd2, 0, 1);
      step("idle",    N, 8'h00, 8'h30, 3'd2, 0, 0);
      step("call_40", C, 8'h40, 8'h40, 3'd3, 0, 1);
      step("idle",    N, 8'h00, 8'h40, 3'd3, 0, 0);
      step("call_50", C, 8'h50, 8'h50, 3'd4, 0, 1);
      step("idle",    N, 8'h00, 8'h50, 3'd4, 0, 0);
      step("call_full", C, 8'h60, 8'h50, 3'd4, 1, 0);
      step("idle",    N, 8'h00, 8'h50, 3'd4, 1, 0);

      step("ret_41",  R, 8'h00, 8'h41, 3'd3, 1, 1);
      step("idle",    N, 8'h00, 8'h41, 3'd3, 1, 0);
      step("ret_31",  R, 8'h00, 8'h31, 3'd2, 1, 1);
      step("idle",    N, 8'h00, 8'h31, 3'd2, 1, 0);
      step("ret_21",  R, 8'h00, 8'h21, 3'd1, 1, 1);
      step("idle",    N, 8'h00, 8'h21, 3'd1, 1, 0);
      step("ret_11",  R, 8'h00, 8'h11, 3'd0, 1, 1);
      step("idle",    N, 8'h00, 8'h11, 3'd0, 1, 0);
      step("ret_empty", R, 8'h00, 8'h11, 3'd0, 1, 0);
      step("idle",    N, 8'h00, 8'h11, 3'd0, 1, 0);

      step("clr",     CLR, 8'h00, 8'h11, 3'd0, 0, 0);
      step("set_wins", CLR | R, 8'h00, 8'h11, 3'd0, 1, 0);
      step("idle",    N, 8'h00, 8'h11, 3'd0, 1, 0);
      step("clr2",    CLR, 8'h00, 8'h11, 3'd0, 0, 0);

      step("jmp_32",  J, 8'h32, 8'h32, 3'd0, 0, 1);
      step("idle",    N, 8'h00, 8'h32, 3'd0, 0, 0);
      step("call_70", C, 8'h70, 8'h70, 3'd1, 0, 1);
      step("idle",    N, 8'h00, 8'h70, 3'd1, 0, 0);
      step("prio",    R | C | I, 8'h90, 8'h33, 3'd0, 0, 1);
      step("prio_l",  N, 8'h00, 8'h33, 3'd0, 0, 0);
      step("no_defer", N, 8'h00, 8'h33, 3'd0, 0, 0);

      step("br_nt",   B, 8'h80, 8'h33, 3'd0, 0, 0);
      step("idle",    N, 8'h00, 8'h33, 3'd0, 0, 0);
      step("br_t",    B | BC, 8'h80, 8'h80, 3'd0, 0, 1);
      step("idle",    N, 8'h00, 8'h80, 3'd0, 0, 0);

      step("b2b_1",   I, 8'h00, 8'h81, 3'd0, 0, 1);
      step("b2b_0",   N, 8'h00, 8'h81, 3'd0, 0, 0);
      step("b2b_2",   I, 8'h00, 8'h82, 3'd0, 0, 1);
      step("b2b_l",   N, 8'h00, 8'h82, 3'd0, 0, 0);

      step("ret_emp2", R, 8'h00, 8'h82, 3'd0, 1, 0);
      step("idle",    N, 8'h00, 8'h82, 3'd0, 1, 0);
      step("call_a0", C, 8'hA0, 8'hA0, 3'd1, 1, 1);
      step("idle",    N, 8'h00, 8'hA0, 3'd1, 1, 0);
      step("call_b0", C, 8'hB0, 8'hB0, 3'd2, 1, 1);
      step("idle",    N, 8'h00, 8'hB0, 3'd2, 1, 0);
      drain();

      // Mid-cycle asynchronous reset with a request held through it.
      #2;
      inc_req = 1'b1;
      rst_n = 1'b0;
      #1;
      compare('{"async_rst", 8'h00, 3'd0, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back('{"rst_inc", 8'h01, 3'd0, 1'b0, 1'b1});
      step("rst_hold", I, 8'h00, 8'h01, 3'd0, 0, 0);
      step("rst_l",    N, 8'h00, 8'h01, 3'd0, 0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
